instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the main decoder (controller_finalr).
- Holds the PC and issues word fetches to instruction memory over a req/valid handshake.
- Latches each returned word into an instruction register and slices it into Opcode/func/register/immediate fields for the decoder, register file and ALU.
- Advances the PC sequentially or by a branch offset when the execute side signals completion.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width in bits.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
- FETCH_TIMEOUT, 16, cycles to wait for imem_valid before error; only used when FETCH_TIMEOUT_EN is defined; range 2..255.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  ADDR_W  fetch address, equal to pc while imem_req=1
- imem_rdata  in  32  returned instruction word
- imem_valid  in  1  imem_rdata valid; sampled only while imem_req=1
- exec_done  in  1  one-cycle pulse: current instruction has completed execute/writeback
- branch_taken  in  1  sampled with exec_done; 1 = take branch (bne resolved downstream)
- instr  out  32  instruction register
- Opcode  out  6  instr[31:26]
- func  out  6  instr[5:0]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- shamt  out  5  instr[10:6]
- imm  out  16  instr[15:0]
- pc  out  ADDR_W  address of the instruction in instr
- pc_plus4  out  ADDR_W  pc+4, modulo 2^ADDR_W
- instr_valid  out  1  instr and its fields are valid for decode
- fetch_err  out  1  sticky fetch timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - State FETCH; pc=RESET_PC; instr=0 (a NOP encoding); instr_valid=0; fetch_err=0; timeout counter=0.
  - imem_req is 0 while rst=0. It asserts in the first cycle after rst deasserts.
- States: FETCH, EXEC, and ERR (ERR exists only with FETCH_TIMEOUT_EN).
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On a clock edge with imem_valid=1: instr<=imem_rdata, instr_valid<=1, go to EXEC. imem_req is 0 from the next cycle.
  - Minimum latency, imem_valid in the same cycle as imem_req: instr_valid rises on the following edge.
- EXEC:
  - imem_req=0; instr, its fields and pc are held stable.
  - On exec_done=1:
    - next pc = pc_plus4 + (sign_extend(imm) << 2) if branch_taken=1, otherwise pc_plus4.
    - All PC arithmetic is modulo 2^ADDR_W and wraps silently.
    - instr_valid<=0; go to FETCH.
- Throughput: at least 2 cycles per instruction.
- Ignored inputs:
  - imem_valid outside FETCH.
  - exec_done outside EXEC.
  - branch_taken without exec_done.
- exec_done in the same cycle that instr_valid rises cannot occur, because instr_valid is registered. If exec_done is already high on the first EXEC cycle, that completes the instruction.
- Reset mid-operation:
  - The in-flight fetch or instruction is abandoned; PC returns to RESET_PC.
  - Instruction memory is required to discard in-flight requests on reset.
- Field outputs are pure slices of instr (no added latency). The decoder qualifies them with instr_valid.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - An 8-bit counter increments each FETCH cycle with imem_valid=0 and clears on entering FETCH.
  - If FETCH_TIMEOUT cycles elapse without imem_valid, go to ERR.
  - ERR: imem_req=0, instr_valid=0, fetch_err=1. ERR is left only by reset.
- When undefined:
  - FETCH waits indefinitely.
  - No counter and no ERR state; fetch_err is tied to 0.

Test Plan:
- Reset release with RESET_PC=0; memory returns 0x20080005 with zero latency -> imem_req=1, imem_addr=0 in cycle 1; cycle 2: instr_valid=1, Opcode=0x08, rt=8, imm=0x0005, pc_plus4=0x4.
- pc=0x10, instr=0x1509FFFF (bne, imm=-1), exec_done=1, branch_taken=1 -> next imem_addr=0x10.
- Same instruction with branch_taken=0 -> next imem_addr=0x14.
- pc=0xFFFFFFFC (ADDR_W=32), exec_done with branch_taken=0 -> next imem_addr=0x0.
- Memory latency of 3 cycles -> imem_req held 4 cycles with imem_addr stable. Spurious imem_valid and exec_done pulses in EXEC/FETCH respectively -> no state change.
- rst=0 asserted during EXEC at pc=0x40 -> instr_valid=0 and imem_req=0 immediately; after release, fetch from 0x0. With FETCH_TIMEOUT_EN and FETCH_TIMEOUT=16, no imem_valid -> fetch_err=1 after 16 FETCH cycles, imem_req=0 thereafter.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, imem req/valid fetch, instruction register and field slicing; optional FETCH_TIMEOUT_EN adds a fetch timeout/ERR state
module instr_fetch_unit #(
    parameter int                 ADDR_W        = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC      = '0,
    parameter int                 FETCH_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    input  logic              exec_done,
    input  logic              branch_taken,
    output logic [31:0]       instr,
    output logic [5:0]        Opcode,
    output logic [5:0]        func,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    output logic              fetch_err
);
`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {FETCH, EXEC, ERR} state_t;
`else
    typedef enum logic [1:0] {FETCH, EXEC} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] br_off;

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign br_off      = ADDR_W'(signed'({instr_q[15:0], 2'b00}));
    assign instr       = instr_q;
    assign Opcode      = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign shamt       = instr_q[10:6];
    assign func        = instr_q[5:0];
    assign imm         = instr_q[15:0];
    assign imem_addr   = pc_q;
    // the reset term keeps the request low while reset is held, since state already reads FETCH then
    assign imem_req    = rst && state_q == FETCH;
    assign instr_valid = state_q == EXEC;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout;

    assign timeout   = state_q == FETCH && !imem_valid && cnt_q == 8'(FETCH_TIMEOUT - 1);
    assign cnt_d     = (state_q == FETCH && !imem_valid) ? cnt_q + 8'd1 : '0;
    assign fetch_err = state_q == ERR;

    // timeout counter, cleared whenever not waiting in FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    logic timeout;
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = FETCH_TIMEOUT != 0;
    assign fetch_err  = 1'b0;
`endif

    // next state: capture the word in FETCH, advance pc in EXEC on completion
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (state_q == FETCH && imem_valid) begin
            instr_d = imem_rdata;
            state_d = EXEC;
        end
        if (state_q == EXEC && exec_done) begin
            pc_d    = branch_taken ? pc_plus4 + br_off : pc_plus4;
            state_d = FETCH;
        end
`ifdef FETCH_TIMEOUT_EN
        if (timeout) state_d = ERR;
`else
        if (timeout) state_d = FETCH;
`endif
    end

    // state, pc and instruction register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end
endmodule
